dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported 32-word data memory between two requesters: port 0 (CPU load/store path) and port 1 (loader/debug master that preloads or inspects memory).
- Sits between the requesters and the memory's address/data_in/write_enable/data_out pins.
- Grants one access per cycle using round-robin arbitration.
- Supports a port-1 lock for bursts, bounded by a starvation limit.
- Returns read data one cycle after grant.

Parameters:
- ADDR_WIDTH, 32, byte address width; the memory word index is addr[6:2].
- DATA_WIDTH, 32, data width.
- LOCK_MAX, 8, maximum consecutive locked port-1 grants while port 0 is requesting; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m0_req  in  1  port 0 access request; held until granted
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  port 0 byte address
- m0_wdata  in  DATA_WIDTH  port 0 write data
- m0_gnt  out  1  port 0 request accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DATA_WIDTH  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- m1_lock  in  1  port 1 requests exclusive ownership while high
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_WIDTH  memory combinational read data
- locked  out  1  arbiter is in LOCKED state

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high.
- Reset values:
  - gnt outputs are combinational and are forced to 0 while reset is high.
  - m0_rvalid=0, m1_rvalid=0, m0_rdata=0, m1_rdata=0, locked=0, mem_we=0.
  - Last-winner pointer resets to 1, so port 0 wins the first tie.
  - Lock counter resets to 0.
- Grant:
  - Combinational in the same cycle the request is seen.
  - At most one gnt per cycle.
  - mem_addr, mem_wdata and mem_we are driven from the granted port.
  - mem_we = winner_we & gnt.
  - With no grant: mem_we=0 and mem_addr/mem_wdata=0.
- Handshake:
  - A request completes on the cycle where req=1 and gnt=1.
  - The requester must hold we/addr/wdata stable while req=1 and gnt=0.
  - Requests may be issued back-to-back.
- Read latency:
  - On a granted read, mem_rdata is captured on that clock edge.
  - The port's rvalid is high for exactly the next cycle, and rdata holds until the next captured read on that port.
  - A granted write produces no rvalid.
- FSM, ARB state:
  - One requester: it wins.
  - Both requesting: the port that is not the last winner wins.
  - The last-winner pointer updates on every grant.
  - If port 1 is granted with m1_lock=1: go to LOCKED and clear the lock counter.
- FSM, LOCKED state (locked=1):
  - Only port 1 can be granted.
  - The counter increments each cycle that m0_req=1, saturating at LOCK_MAX.
  - Exit to ARB when m1_lock=0, or when counter=LOCK_MAX and m0_req=1.
  - On a forced exit, port 0 is granted in that same cycle, port 1 is not, and the pointer becomes 0.
  - On a voluntary exit (m1_lock=0), normal round-robin applies in that cycle.
- Boundary conditions:
  - Simultaneous read and write by different ports in one cycle is impossible (single grant).
  - A read granted in the cycle after a write to the same address returns the new data.
  - m1_lock asserted without m1_req has no effect.
  - Reset mid-burst returns to ARB and drops pending rvalid.
  - Address bits above [6:2] are passed through unmodified.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds outputs m0_gnt_count[15:0] and m1_gnt_count[15:0].
  - Each counts that port's grants and saturates at 16'hFFFF.
  - Both clear to 0 on reset.
  - Adds a stall_count[15:0] output: cycles with m0_req=1 and m0_gnt=0, saturating.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single port 0 write then read: m0 write addr 0x08, data 0xDEADBEEF, then read 0x08 -> m0_gnt each cycle, mem_we=1 in the first cycle only, m0_rvalid=1 in cycle 3 with m0_rdata=0xDEADBEEF.
- Round-robin: both ports hold read requests for 4 cycles after reset -> grants in order m0, m1, m0, m1, each rvalid exactly one cycle after its grant.
- Voluntary lock: m1 locked burst of 3 writes to 0x00/0x04/0x08 with m0 idle, then m1_lock=0 -> locked=1 for the burst, then ARB, and memory words 0..2 are updated.
- Forced lock exit: m1 locked continuously, m0 requesting, LOCK_MAX=8 -> port 1 gets 8 grants, then m0_gnt=1 and locked=0 in the same cycle.
- Reset mid-operation: read granted to m1, reset asserted on the next cycle -> m1_rvalid=0, locked=0, and the next tie goes to m0.
- With DMEM_ARB_STATS_EN: 5 m0 grants, 3 m1 grants, 2 m0 stall cycles -> counters read 5/3/2, and 0 after reset.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Pin bundle between two data-memory requesters, the dmem arbiter and the single-ported data memory.
// slave: the arbiter's view; master: the requesters and memory model driving it.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_lock;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  locked;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_we, locked,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_we, locked,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin share of the single-ported data memory between the CPU port (0) and a loader port (1) with a bounded port-1 lock.
// Grant is combinational, read data returns one cycle after grant; DMEM_ARB_STATS_EN adds grant/stall counters.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic          clk,
    input  logic          reset,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   m0_gnt_count,
    output logic [15:0]   m1_gnt_count,
    output logic [15:0]   stall_count,
`endif
    dmem_arbiter_if.slave bus
);
    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_winner;
    logic                  last_winner_next;
    logic [7:0]            lock_cnt;
    logic [7:0]            lock_cnt_next;
    logic                  rr0;
    logic                  rr1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  owned;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // last_winner = 1 means port 1 won last, so port 0 takes the next tie
    assign rr0 = bus.m0_req & (~bus.m1_req | last_winner);
    assign rr1 = bus.m1_req & (~bus.m0_req | ~last_winner);

    always_comb begin
        state_next       = state;
        last_winner_next = last_winner;
        lock_cnt_next    = lock_cnt;
        gnt0             = 1'b0;
        gnt1             = 1'b0;
        owned            = 1'b0;
        if (!reset) begin
            case (state)
                ARB: begin
                    gnt0 = rr0;
                    gnt1 = rr1;
                    if (rr1 && bus.m1_lock) begin
                        state_next    = LOCKED;
                        lock_cnt_next = 8'd0;
                    end
                end
                LOCKED: begin
                    if (!bus.m1_lock) begin
                        gnt0       = rr0;
                        gnt1       = rr1;
                        state_next = ARB;
                    end else if (bus.m0_req && lock_cnt == LOCK_LIMIT) begin
                        gnt0       = 1'b1;
                        state_next = ARB;
                    end else begin
                        owned = 1'b1;
                        gnt1  = bus.m1_req;
                        if (bus.m0_req && lock_cnt != LOCK_LIMIT) begin
                            lock_cnt_next = lock_cnt + 8'd1;
                        end
                    end
                end
                default: state_next = ARB;
            endcase
            if (gnt0) begin
                last_winner_next = 1'b0;
            end else if (gnt1) begin
                last_winner_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB;
            last_winner <= 1'b1;
            lock_cnt    <= 8'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state       <= state_next;
            last_winner <= last_winner_next;
            lock_cnt    <= lock_cnt_next;
            rvalid0_q   <= gnt0 & ~bus.m0_we;
            rvalid1_q   <= gnt1 & ~bus.m1_we;
            if (gnt0 && !bus.m0_we) begin
                rdata0_q <= bus.mem_rdata;
            end
            if (gnt1 && !bus.m1_we) begin
                rdata1_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (gnt0) begin
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            bus.mem_we    = bus.m0_we;
        end else if (gnt1) begin
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            bus.mem_we    = bus.m1_we;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    // A read granted just before reset must not be reported during reset
    assign bus.m0_rvalid = rvalid0_q & ~reset;
    assign bus.m1_rvalid = rvalid1_q & ~reset;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    // High only while port 1 actually holds exclusive ownership this cycle
    assign bus.locked    = owned;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_gnt_count <= 16'd0;
            m1_gnt_count <= 16'd0;
            stall_count  <= 16'd0;
        end else begin
            if (gnt0 && m0_gnt_count != 16'hFFFF) begin
                m0_gnt_count <= m0_gnt_count + 16'd1;
            end
            if (gnt1 && m1_gnt_count != 16'hFFFF) begin
                m1_gnt_count <= m1_gnt_count + 16'd1;
            end
            if (bus.m0_req && !gnt0 && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built; arbitration is unaffected.
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a cycle-level reference of the arbitration rules.
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] m0_gnt_count;
    logic [15:0] m1_gnt_count;
    logic [15:0] stall_count;
`endif

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DMEM_ARB_STATS_EN
        .m0_gnt_count (m0_gnt_count),
        .m1_gnt_count (m1_gnt_count),
        .stall_count  (stall_count),
`endif
        .bus          (bus)
    );

    // Environment memory: combinational read, write on the clock edge
    logic [31:0] mem [32];
    assign bus.mem_rdata = mem[bus.mem_addr[6:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [32];
    int          m_last = 1;
    bit          m_own  = 1'b0;
    int          m_run  = 0;
    bit   [1:0]  m_rv   = 2'b00;
    logic [31:0] m_rd [2] = '{32'd0, 32'd0};

    int           win;
    logic [5:0]   exp_c, obs_c;     // {gnt0, gnt1, mem_we, locked, rvalid0, rvalid1}
    logic [63:0]  exp_bus, obs_bus; // {mem_addr, mem_wdata}
    logic [63:0]  exp_rd, obs_rd;   // {m0_rdata, m1_rdata}

    function automatic logic [31:0] rnd_addr(input int w);
        logic [31:0] a;
        a = $urandom;
        a[6:2] = 5'(w);
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                         input bit lk);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        bus.m1_lock = lk;
    endtask

    // One clock: predict and sample outputs mid-cycle, then advance the model across the edge
    task automatic cyc();
        bit          forced;
        bit          we;
        logic [31:0] a, d;
        int          idx;
        #1;
        forced = m_own && bus.m1_lock && bus.m0_req && (m_run == LOCK_MAX);
        if (reset) win = -1;
        else if (m_own && bus.m1_lock) win = forced ? 0 : (bus.m1_req ? 1 : -1);
        else if (bus.m0_req && bus.m1_req) win = 1 - m_last;
        else if (bus.m0_req) win = 0;
        else if (bus.m1_req) win = 1;
        else win = -1;
        we = (win == 0) ? bus.m0_we : (win == 1) ? bus.m1_we : 1'b0;
        a  = (win == 0) ? bus.m0_addr : (win == 1) ? bus.m1_addr : 32'd0;
        d  = (win == 0) ? bus.m0_wdata : (win == 1) ? bus.m1_wdata : 32'd0;
        exp_c   = {win == 0, win == 1, we, !reset && m_own && bus.m1_lock && !forced,
                   m_rv[0] && !reset, m_rv[1] && !reset};
        exp_bus = {a, d};
        exp_rd  = {m_rd[0], m_rd[1]};
        obs_c   = {bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.locked, bus.m0_rvalid, bus.m1_rvalid};
        obs_bus = {bus.mem_addr, bus.mem_wdata};
        obs_rd  = {bus.m0_rdata, bus.m1_rdata};
        @(posedge clk);
        if (reset) begin
            m_own = 1'b0; m_run = 0; m_last = 1; m_rv = 2'b00; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
        end else begin
            m_rv = 2'b00;
            if (win >= 0) begin
                idx = int'(a[6:2]);
                if (we) ref_mem[idx] = d;
                else begin
                    m_rd[win] = ref_mem[idx];
                    m_rv[win] = 1'b1;
                end
                m_last = win;
            end
            if (m_own) begin
                if (!bus.m1_lock || forced) m_own = 1'b0;
                else if (bus.m0_req && m_run < LOCK_MAX) m_run++;
            end else if (win == 1 && bus.m1_lock) begin
                m_own = 1'b1;
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, rnd_addr(3), $urandom, 1, 1, rnd_addr(5), $urandom, 1);
        reset = 1'b1;
        @(negedge clk);
        cyc();
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL reset_model cyc%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== 134'd0) begin
                errors++;
                $display("FAIL reset_values got ctrl=%b bus=%h rd=%h want all zero", obs_c, obs_bus, obs_rd);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_preload();
        for (int w = 0; w < 32; w++) begin
            drive(1, 1, rnd_addr(w), $urandom, 0, 0, 32'd0, 32'd0, 0);
            cyc();
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL preload w%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         w, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
        end
    endtask

    task automatic test_write_read();
        logic [5:0] seen [3];
        logic [31:0] rd_seen;
        drive(1, 1, 32'h08, 32'hDEADBEEF, 0, 0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(1, 0, 32'h08, 32'd0, 0, 0, 32'd0, 32'd0, 0);
            if (i == 2) drive(1, 0, 32'h0C, 32'd0, 0, 0, 32'd0, 32'd0, 0);
            cyc();
            seen[i] = obs_c;
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL write_read cyc%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
        end
        rd_seen = obs_rd[63:32];
        checks++;
        if ({seen[0][5], seen[0][3], seen[1][5], seen[1][3], seen[2][5], seen[2][3]} !== 6'b11_10_10) begin
            errors++;
            $display("FAIL wr_gnt_we got %b%b %b%b %b%b want 11 10 10", seen[0][5], seen[0][3],
                     seen[1][5], seen[1][3], seen[2][5], seen[2][3]);
        end
        checks++;
        if ({seen[1][1], seen[2][1], rd_seen} !== {2'b01, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL rd_latency got rvalid=%b%b rdata=%h want rvalid=01 rdata=deadbeef",
                     seen[1][1], seen[2][1], rd_seen);
        end
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
        cyc();
    endtask

    task automatic test_round_robin();
        logic [31:0] a0, a1;
        logic [7:0]  order;
        reset = 1'b1;
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
        cyc();
        reset = 1'b0;
        a0 = rnd_addr($urandom_range(0, 31));
        a1 = rnd_addr($urandom_range(0, 31));
        order = 8'd0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 0, a0, 32'd0, 1, 0, a1, 32'd0, 0);
            else drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
            cyc();
            if (i < 4) order = {order[5:0], obs_c[5], obs_c[4]};
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL round_robin cyc%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
            if (win == 0) a0 = rnd_addr($urandom_range(0, 31));
            if (win == 1) a1 = rnd_addr($urandom_range(0, 31));
        end
        checks++;
        if (order !== 8'b10_01_10_01) begin
            errors++;
            $display("FAIL rr_order got %b want 10011001", order);
        end
    endtask

    task automatic test_voluntary_lock();
        logic [31:0] dv [3];
        bit   [2:0]  lk;
        logic [5:0]  after;
        logic [5:0]  nolock;
        logic [95:0] rds;
        for (int i = 0; i < 3; i++) begin
            dv[i] = $urandom;
            drive(0, 0, 32'd0, 32'd0, 1, 1, 32'(i * 4), dv[i], 1);
            cyc();
            lk[i] = obs_c[2];
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL vlock_burst i%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
        end
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
                1: drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 1);
                2, 3, 4: drive(1, 0, 32'((i - 2) * 4), 32'd0, 0, 0, 32'd0, 32'd0, 1);
                default: drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
            endcase
            cyc();
            if (i == 0) after = obs_c;
            if (i == 2) nolock = obs_c;
            if (i >= 3) rds[(i - 3) * 32 +: 32] = obs_rd[63:32];
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL vlock_after i%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
        end
        checks++;
        if ({lk, after[2]} !== 4'b110_0) begin
            errors++;
            $display("FAIL vlock_locked got burst=%b exit=%b want burst=110 exit=0", lk, after[2]);
        end
        checks++;
        if ({nolock[5], nolock[2]} !== 2'b10) begin
            errors++;
            $display("FAIL lock_without_req got gnt0=%b locked=%b want gnt0=1 locked=0", nolock[5], nolock[2]);
        end
        checks++;
        if (rds !== {dv[2], dv[1], dv[0]}) begin
            errors++;
            $display("FAIL vlock_mem got %h want %h", rds, {dv[2], dv[1], dv[0]});
        end
    endtask

    task automatic test_forced_exit();
        logic [31:0] a0, a1, d1;
        int run;
        bit done, exit_locked;
        reset = 1'b1;
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
        cyc();
        reset = 1'b0;
        a0 = rnd_addr($urandom_range(0, 31));
        a1 = rnd_addr($urandom_range(0, 31));
        d1 = $urandom;
        run = 0; done = 1'b0; exit_locked = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i < 14) drive(1, 0, a0, 32'd0, 1, 1, a1, d1, 1);
            else drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
            cyc();
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL forced_exit cyc%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
            if (!done) begin
                if (obs_c[4] && obs_c[2]) run++;
                if (obs_c[5] && run > 0) begin
                    done = 1'b1;
                    exit_locked = obs_c[2];
                end
            end
            if (win == 0) a0 = rnd_addr($urandom_range(0, 31));
            if (win == 1) begin
                a1 = rnd_addr($urandom_range(0, 31));
                d1 = $urandom;
            end
        end
        checks++;
        if (run != LOCK_MAX || {done, exit_locked} !== 2'b10) begin
            errors++;
            $display("FAIL forced_limit got run=%0d exit_seen=%b locked_at_exit=%b want run=%0d 1 0",
                     run, done, exit_locked, LOCK_MAX);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] in_rst, post;
        reset = 1'b1;
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0, 1: drive(0, 0, 32'd0, 32'd0, 1, 0, rnd_addr($urandom_range(0, 31)), 32'd0, 1);
                2: begin
                    reset = 1'b1;
                    drive(1, 0, rnd_addr(1), 32'd0, 1, 0, rnd_addr(2), 32'd0, 1);
                end
                3: begin
                    reset = 1'b0;
                    drive(1, 0, rnd_addr(1), 32'd0, 1, 0, rnd_addr(2), 32'd0, 0);
                end
                default: drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
            endcase
            cyc();
            if (i == 2) in_rst = obs_c;
            if (i == 3) post = obs_c;
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL reset_mid cyc%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
        end
        checks++;
        if (in_rst !== 6'b000000) begin
            errors++;
            $display("FAIL reset_drop got ctrl=%b want 000000", in_rst);
        end
        checks++;
        if (post[5:4] !== 2'b10) begin
            errors++;
            $display("FAIL reset_tie got gnt=%b want 10", post[5:4]);
        end
    endtask

    task automatic test_random();
        bit r0 = 0, w0 = 0, r1 = 0, w1 = 0, lk = 0;
        logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!r0 && $urandom_range(0, 9) < 6) begin
                r0 = 1; w0 = 1'($urandom); a0 = rnd_addr($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!r1 && $urandom_range(0, 9) < 6) begin
                r1 = 1; w1 = 1'($urandom); a1 = rnd_addr($urandom_range(0, 31)); d1 = $urandom;
            end
            if ($urandom_range(0, 9) < 2) lk = ~lk;
            reset = ($urandom_range(0, 99) < 2);
            drive(r0, w0, a0, d0, r1, w1, a1, d1, lk);
            cyc();
            checks++;
            if ({obs_c, obs_bus, obs_rd} !== {exp_c, exp_bus, exp_rd}) begin
                errors++;
                $display("FAIL random cyc%0d got ctrl=%b bus=%h rd=%h want ctrl=%b bus=%h rd=%h",
                         i, obs_c, obs_bus, obs_rd, exp_c, exp_bus, exp_rd);
            end
            if (win == 0) r0 = 0;
            if (win == 1) r1 = 0;
        end
        reset = 1'b0;
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1, 0, rnd_addr(i), 32'd0, 1, 0, rnd_addr(i + 8), 32'd0, 0);
            else if (i < 7) drive(1, 0, rnd_addr(i), 32'd0, 0, 0, 32'd0, 32'd0, 0);
            else drive(0, 0, 32'd0, 32'd0, 1, 1, rnd_addr(i), $urandom, 0);
            cyc();
        end
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
        #1;
        checks++;
        if ({m0_gnt_count, m1_gnt_count, stall_count} !== {16'd5, 16'd3, 16'd2}) begin
            errors++;
            $display("FAIL stats_counts got %0d/%0d/%0d want 5/3/2", m0_gnt_count, m1_gnt_count, stall_count);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if ({m0_gnt_count, m1_gnt_count, stall_count} !== 48'd0) begin
            errors++;
            $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", m0_gnt_count, m1_gnt_count, stall_count);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_round_robin();
        test_voluntary_lock();
        test_forced_exit();
        test_reset_mid();
        test_random();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
